// File: rtl/tt6581_spi_pkg.sv
// Shared types and helpers for the tt6581 SPI command master.
package tt6581_spi_pkg;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module spi_cmd_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

    logic [PtrW:0]      wptr_q;
    logic [PtrW:0]      rptr_q;
    logic [Width-1:0]   mem_q [Depth];

    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI master (CPOL=0, CPHA=0) that turns queued register commands into {we, addr, data} frames.
module spi_cmd_master
    import tt6581_spi_pkg::*;
#(
    parameter int unsigned ADDR_W        = 7,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned CS_GAP        = 4,
    parameter bit          CS_ACTIVE_LOW = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              cs_o,
    output logic              mosi_o,
    input  logic              miso_i
);
    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned HalfW   = $clog2(CLK_DIV + 1);
    localparam int unsigned BitW    = $clog2(FRAME_W + 1);
    localparam int unsigned GapW    = $clog2(CS_GAP + 1);

    localparam logic             CsOn     = CS_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic [HalfW-1:0] HalfLoad = HalfW'(CLK_DIV - 1);
    localparam logic [HalfW-1:0] HalfOne  = HalfW'(1);
    localparam logic [BitW-1:0]  BitLoad  = BitW'(FRAME_W - 1);
    localparam logic [BitW-1:0]  BitOne   = BitW'(1);
    localparam logic [GapW-1:0]  GapLoad  = GapW'(CS_GAP - 1);
    localparam logic [GapW-1:0]  GapOne   = GapW'(1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t               push_cmd;
    logic [FRAME_W-1:0] pop_word;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    state_e             state_q;
    logic [HalfW-1:0]   half_q;
    logic [BitW-1:0]    bit_q;
    logic [GapW-1:0]    gap_q;
    logic [FRAME_W-1:0] tx_q;
    logic [DATA_W-1:0]  rx_q;
    logic               we_q;
    logic               sclk_q;
    logic               cs_q;
    logic               mosi_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    // Reads put zeros on the wire in the data field.
    always_comb begin
        push_cmd       = '0;
        push_cmd.we    = cmd_we_i;
        push_cmd.addr  = cmd_addr_i;
        push_cmd.wdata = cmd_we_i ? cmd_wdata_i : '0;
    end

    assign pop = (state_q == StIdle) && !fifo_empty;

    spi_cmd_fifo #(
        .Width (FRAME_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (pop_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            half_q      <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            we_q        <= 1'b0;
            sclk_q      <= 1'b0;
            cs_q        <= ~CsOn;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StSetup;
                        half_q  <= HalfLoad;
                        cs_q    <= CsOn;
                        mosi_q  <= pop_word[FRAME_W-1];
                        tx_q    <= {pop_word[FRAME_W-2:0], 1'b0};
                        we_q    <= pop_word[FRAME_W-1];
                    end
                end
                StSetup: begin
                    if (half_q == '0) begin
                        state_q <= StShift;
                        half_q  <= HalfLoad;
                        bit_q   <= BitLoad;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[DATA_W-2:0], miso_i};
                    end else begin
                        half_q <= half_q - HalfOne;
                    end
                end
                StShift: begin
                    if (half_q != '0) begin
                        half_q <= half_q - HalfOne;
                    end else begin
                        half_q <= HalfLoad;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            // Final falling edge ends the frame; the wire idles low.
                            if (bit_q == '0) begin
                                state_q <= StHold;
                                mosi_q  <= 1'b0;
                            end else begin
                                mosi_q <= tx_q[FRAME_W-1];
                                tx_q   <= tx_q << 1;
                                bit_q  <= bit_q - BitOne;
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[DATA_W-2:0], miso_i};
                        end
                    end
                end
                StHold: begin
                    if (half_q == '0) begin
                        state_q <= StGap;
                        gap_q   <= GapLoad;
                        cs_q    <= ~CsOn;
                        if (!we_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rx_q;
                        end
                    end else begin
                        half_q <= half_q - HalfOne;
                    end
                end
                StGap: begin
                    if (gap_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - GapOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o = !fifo_full;
    assign busy_o      = (state_q != StIdle) || !fifo_empty;
    assign sclk_o      = sclk_q;
    assign cs_o        = cs_q;
    assign mosi_o      = mosi_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
